// File: rtl/permutation_sequencer.sv
// rtl/permutation_sequencer.sv - Ascon permutation state register, round counter and p12/p6 sequencing FSM.
// Optional macro PERM_ABORT_EN adds abort_i to cancel a running permutation.
module permutation_sequencer #(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         mode_i,
`ifdef PERM_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic [319:0] state_i,
  input  logic [319:0] diff_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] FIRST_A = 4'd0;
  localparam logic [3:0] FIRST_B = 4'(NB_ROUNDS_A - NB_ROUNDS_B);
  localparam logic [3:0] LAST    = 4'(NB_ROUNDS_A - 1);

  typedef enum logic {S_IDLE, S_RUN} fsm_e;

  fsm_e         fsm_q;
  logic [319:0] state_q;
  logic [3:0]   round_q;
  logic [3:0]   round_d;
  logic         done_q;
  logic         abort_w;

`ifdef PERM_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  assign round_d = round_q + 4'd1;

  // The diffusion result is captured on every RUN edge, including the abort
  // edge, so an aborted run leaves the last completed round in state_q.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= state_i;
            round_q <= mode_i ? FIRST_B : FIRST_A;
            fsm_q   <= S_RUN;
          end
        end
        S_RUN: begin
          state_q <= diff_i;
          if (abort_w) begin
            round_q <= '0;
            fsm_q   <= S_IDLE;
          end else if (round_q == LAST) begin
            round_q <= '0;
            fsm_q   <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            round_q <= round_d;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o  = (fsm_q == S_RUN);
  assign done_o  = done_q;

endmodule

// File: tb/tb_permutation_sequencer.sv
// tb/tb_permutation_sequencer.sv - directed bench for permutation_sequencer with a word-increment diffusion stub.
module tb_permutation_sequencer;

  logic         clk = 1'b0;
  logic         resetb;
  logic         start;
  logic         mode;
`ifdef PERM_ABORT_EN
  logic         abort;
`endif
  logic [319:0] state_in;
  logic [319:0] diff;
  logic [319:0] state_out;
  logic [3:0]   round;
  logic         busy;
  logic         done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  permutation_sequencer dut (
    .clock_i (clk),
    .resetb_i(resetb),
    .start_i (start),
    .mode_i  (mode),
`ifdef PERM_ABORT_EN
    .abort_i (abort),
`endif
    .state_i (state_in),
    .diff_i  (diff),
    .state_o (state_out),
    .round_o (round),
    .busy_o  (busy),
    .done_o  (done)
  );

  // Round-chain stand-in: each 64-bit word of the state increments by one.
  always_comb begin
    diff = '0;
    for (int k = 0; k < 5; k++) diff[64*k +: 64] = state_out[64*k +: 64] + 64'd1;
  end

  function automatic logic [319:0] add_words(input logic [319:0] s, input logic [63:0] n);
    logic [319:0] r;
    for (int k = 0; k < 5; k++) r[64*k +: 64] = s[64*k +: 64] + n;
    return r;
  endfunction

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [319:0] vec_a, vec_b, vec_c, cur;

  initial begin
    vec_a = {64'h044d33702433805d, 64'hb22e133e424f0250, 64'h4b81c0cbbdb5fc1a,
             64'hbc7a2e775aababf7, 64'h78e2cc41faabaa1a};
    vec_b = {5{64'h0123456789abcdef}};
    vec_c = {64'h5, 64'h4, 64'h3, 64'h2, 64'h1};

    // Reset with start held high: nothing may be accepted
    resetb = 1'b0; start = 1'b1; mode = 1'b0; state_in = vec_a;
`ifdef PERM_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    check("rst_state", state_out, '0);
    check("rst_round", {316'd0, round}, 320'd0);
    check("rst_busy", {319'd0, busy}, 320'd0);
    check("rst_done", {319'd0, done}, 320'd0);
    start = 1'b0; resetb = 1'b1;
    step();
    check("idle_busy", {319'd0, busy}, 320'd0);

    // p12 from all-zero state
    state_in = '0; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("p12_round%0d", i), {316'd0, round}, 320'(i));
      check($sformatf("p12_busy%0d", i), {319'd0, busy}, 320'd1);
      check($sformatf("p12_done%0d", i), {319'd0, done}, 320'd0);
      step();
    end
    check("p12_done", {319'd0, done}, 320'd1);
    check("p12_idle", {319'd0, busy}, 320'd0);
    check("p12_result", state_out, {5{64'h000000000000000C}});
    step();
    check("p12_done_pulse", {319'd0, done}, 320'd0);
    check("p12_hold", state_out, {5{64'h000000000000000C}});

    // p6 from the reference vector
    state_in = vec_a; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("p6_round%0d", i), {316'd0, round}, 320'(6 + i));
      check($sformatf("p6_done%0d", i), {319'd0, done}, 320'd0);
      step();
    end
    check("p6_done", {319'd0, done}, 320'd1);
    check("p6_result", state_out, add_words(vec_a, 64'd6));
    check("p6_word0", {256'd0, state_out[63:0]}, {256'd0, 64'h78e2cc41faabaa20});

    // Start during RUN is ignored
    state_in = vec_b; mode = 1'b1; start = 1'b1;
    step();
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("ign_round%0d", c), {316'd0, round}, 320'(5 + c));
      if (c == 5) begin
        start = 1'b1; state_in = vec_c; mode = 1'b0;
      end else begin
        start = 1'b0;
      end
      step();
    end
    check("ign_done", {319'd0, done}, 320'd1);
    check("ign_result", state_out, add_words(vec_b, 64'd6));
    step();
    check("ign_no_restart", {319'd0, busy}, 320'd0);

    // Back-to-back p6 with start held high
    cur = vec_a; state_in = vec_a; mode = 1'b1; start = 1'b1;
    step();
    for (int p = 0; p < 3; p++) begin
      for (int c = 1; c <= 6; c++) begin
        check($sformatf("b2b%0d_busy%0d", p, c), {319'd0, busy}, 320'd1);
        check($sformatf("b2b%0d_nodone%0d", p, c), {319'd0, done}, 320'd0);
        step();
      end
      check($sformatf("b2b%0d_done", p), {319'd0, done}, 320'd1);
      check($sformatf("b2b%0d_result", p), state_out, add_words(cur, 64'd6));
      cur = (p == 0) ? vec_b : vec_c;
      state_in = cur;
      if (p == 2) start = 1'b0;
      step();
    end
    check("b2b_end_idle", {319'd0, busy}, 320'd0);

    // Reset mid-RUN at round 4
    state_in = vec_b; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_round4", {316'd0, round}, 320'd4);
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    check("mid_rst_state", state_out, '0);
    check("mid_rst_busy", {319'd0, busy}, 320'd0);
    check("mid_rst_round", {316'd0, round}, 320'd0);
    check("mid_rst_done", {319'd0, done}, 320'd0);
    step();
    check("mid_rst_nodone", {319'd0, done}, 320'd0);

`ifdef PERM_ABORT_EN
    // Abort at round 4, with abort and start both high at the start edge
    state_in = vec_c; mode = 1'b0; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abt_started", {319'd0, busy}, 320'd1);
    for (int i = 0; i < 4; i++) step();
    check("abt_round4", {316'd0, round}, 320'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abt_busy", {319'd0, busy}, 320'd0);
    check("abt_round", {316'd0, round}, 320'd0);
    check("abt_state", state_out, add_words(vec_c, 64'd5));
    check("abt_done", {319'd0, done}, 320'd0);
    step();
    check("abt_nodone", {319'd0, done}, 320'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
